// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with frame-synchronous data update,
// leading-zero blanking, per-digit decimal points and anti-ghost blanking.
module seven_seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      resetIN,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic [NUM_DIGITS-1:0]     anDisplay,
  output logic [7:0]                outDisplay,
  output logic                      frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_BITS-1:0]   BLANK_LIM = DIV_BITS'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  logic [DIV_BITS-1:0]     cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pending_value;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic [4*NUM_DIGITS-1:0] active_value;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    slot_end;
  logic                    wrap;

  logic [3:0]              nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic                    lz_run;
  logic                    suppressed;
  logic                    show;

  assign slot_end = &cnt;
  assign wrap     = slot_end && (idx == LAST_IDX);

  // Displayed data only changes on the frame wrap so a frame never tears.
  always_ff @(posedge clk) begin
    if (resetIN) begin
      cnt           <= '0;
      idx           <= '0;
      pending_value <= '0;
      pending_dp    <= '0;
      active_value  <= '0;
      active_dp     <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
      if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (load) begin
        pending_value <= value;
        pending_dp    <= dp;
      end
      if (wrap) begin
        active_value <= load ? value : pending_value;
        active_dp    <= load ? dp    : pending_dp;
      end
    end
  end

  always_comb begin
    nib        = '0;
    cur_dp     = 1'b0;
    an_hot     = '0;
    lz_run     = 1'b1;
    suppressed = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = active_value[4*i +: 4];
        cur_dp    = active_dp[i];
        an_hot[i] = 1'b1;
      end
    end
    // lz_run holds "nibbles NUM_DIGITS-1 down to i are all zero"; digit 0 is never checked.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run & (active_value[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        suppressed = blank_lz & lz_run;
      end
    end
  end

  assign show = (cnt >= BLANK_LIM) && !suppressed;

  always_ff @(posedge clk) begin
    if (resetIN) begin
      anDisplay  <= AN_OFF;
      outDisplay <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (show) begin
        anDisplay  <= an_hot ^ AN_OFF;
        outDisplay <= {cur_dp, decode(nib)} ^ SEG_OFF;
      end else begin
        anDisplay  <= AN_OFF;
        outDisplay <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench for seven_seg_scan_mux: a 4-digit active-low instance driven
// with directed and random traffic, plus a 3-digit active-high instance on shared reset.
module tb_seven_seg_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetIN  = 1'b1;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value    = '0;
  logic [3:0]  dp       = '0;
  logic [3:0]  anDisplay;
  logic [7:0]  outDisplay;
  logic        frame_tick;

  logic [11:0] value3    = '0;
  logic [2:0]  dp3       = '0;
  logic        load3     = 1'b0;
  logic        blank_lz3 = 1'b0;
  logic [2:0]  an3;
  logic [7:0]  seg3;
  logic        tick3;

  seven_seg_scan_mux #(.NUM_DIGITS(4), .DIV_BITS(2), .BLANK_CYCLES(1), .ACTIVE_LOW(1)) dut (
    .clk(clk), .resetIN(resetIN), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .anDisplay(anDisplay), .outDisplay(outDisplay),
    .frame_tick(frame_tick)
  );

  seven_seg_scan_mux #(.NUM_DIGITS(3), .DIV_BITS(2), .BLANK_CYCLES(1), .ACTIVE_LOW(0)) dut3 (
    .clk(clk), .resetIN(resetIN), .value(value3), .dp(dp3), .load(load3),
    .blank_lz(blank_lz3), .anDisplay(an3), .outDisplay(seg3),
    .frame_tick(tick3)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       tick;
    logic [2:0] an3;
    logic [7:0] seg3;
    logic       tick3;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Cycles since the last reset edge; slot position and digit derive from it.
  int          t = 0;
  logic [15:0] m_pend_v = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [15:0] m_act_v = '0;
  logic [3:0]  m_act_dp = '0;

  logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (t=%0d, time=%0t)", tag, got, want, t, $time);
    end
  endtask

  task automatic modelEdge();
    exp_t e;
    int   c, dg, dg3;
    logic supp;
    if (resetIN) begin
      t = 0;
      m_pend_v = '0; m_pend_dp = '0; m_act_v = '0; m_act_dp = '0;
      e.an = 4'hF; e.seg = 8'hFF; e.tick = 1'b0;
      e.an3 = 3'b000; e.seg3 = 8'h00; e.tick3 = 1'b0;
    end else begin
      c   = t % 4;
      dg  = (t / 4) % 4;
      dg3 = (t / 4) % 3;
      supp = 1'b0;
      if (blank_lz && dg >= 1) begin
        supp = 1'b1;
        for (int k = dg; k < 4; k++) if (m_act_v[4*k +: 4] != 4'h0) supp = 1'b0;
      end
      if (c == 0 || supp) begin
        e.an = 4'hF; e.seg = 8'hFF;
      end else begin
        e.an  = ~(4'b0001 << dg);
        e.seg = ~{m_act_dp[dg], seg_lut[m_act_v[4*dg +: 4]]};
      end
      if (c == 0) begin
        e.an3 = 3'b000; e.seg3 = 8'h00;
      end else begin
        e.an3 = 3'b001 << dg3; e.seg3 = 8'h3F;
      end
      t++;
      e.tick  = (t % 16 == 0);
      e.tick3 = (t % 12 == 0);
      if (load) begin
        m_pend_v = value; m_pend_dp = dp;
      end
      if (t % 16 == 0) begin
        m_act_v = m_pend_v; m_act_dp = m_pend_dp;
      end
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic blz,
                               input logic [15:0] v, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      resetIN  = rst;
      load     = ld;
      blank_lz = blz;
      value    = v;
      dp       = d;
      modelEdge();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitPhase(input int phase, input logic blz);
    int guard = 0;
    while (t % 16 != phase && guard < 40) begin
      applyStimulus(1'b0, 1'b0, blz, 16'h0, 4'h0, 1);
      guard++;
    end
    checkOutput("phase_reach", 32'(t % 16), 32'(phase));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("an4",   32'(anDisplay),  32'(e.an));
        checkOutput("seg4",  32'(outDisplay), 32'(e.seg));
        checkOutput("tick4", 32'(frame_tick), 32'(e.tick));
        checkOutput("an3",   32'(an3),        32'(e.an3));
        checkOutput("seg3",  32'(seg3),       32'(e.seg3));
        checkOutput("tick3", 32'(tick3),      32'(e.tick3));
      end
    end
  end

  initial begin
    // Reset, then idle through the first frame wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 20);

    // Mid-frame load shows only after the next wrap.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1230, 4'b0100, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 30);

    // Leading-zero blanking.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 36);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 4'b1110, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 36);

    // Load exactly on the wrap cycle overrides an older pending value.
    waitPhase(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111, 4'b0011, 1);
    waitPhase(15, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hABCD, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 20);

    // Reset in the digit 2 slot.
    waitPhase(9, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 20);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom),
                    4'($urandom_range(0, 15)), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 2);

    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
